operand_sequencer: RTL
======================

Name: operand_sequencer

Overview:
Parametrised operand fetch engine for the multiplier datapath. It walks a block-RAM of packed operand pairs, accounts for the RAM read latency, and presents each pair {a,b} downstream on a valid/ready handshake with back-pressure. It supports single-pass and continuous-loop modes and signals the end of a pass. It sits between the operand BRAM (port A) and the Dadda multiplier input registers.

Parameters:
OP_W, 16, width of each operand a and b; the RAM word width is 2*OP_W.
ADDR_W, 4, RAM address width.
NUM_WORDS, 16, number of operand pairs per pass; must satisfy 1 <= NUM_WORDS <= 2**ADDR_W.
RD_LAT, 1, RAM read latency in clka cycles from ena/addra to valid douta; must be 1..4.
LOOP_MODE, 0, 0 = single pass then stop, 1 = wrap to address 0 while start_stop is held.

Ports:
clka  in  1  clock; single clock domain.
reset  in  1  asynchronous, active-high reset.
start_stop  in  1  level run request; 1 = run or keep running, 0 = stop issuing.
douta  in  2*OP_W  RAM read data.
addra  out  ADDR_W  RAM read address.
ena  out  1  RAM read enable; 1 only on cycles that issue a read.
a  out  OP_W  operand a = douta[2*OP_W-1:OP_W] of the delivered word.
b  out  OP_W  operand b = douta[OP_W-1:0] of the delivered word.
op_valid  out  1  a and b are valid.
op_ready  in  1  downstream accepts; transfer occurs when op_valid && op_ready.
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse when a pass or stop completes.
pass_cnt  out  8  completed passes since leaving IDLE; wraps at 255.

Behaviour:
- Reset (async, any state): state=IDLE; addra=0, ena=0, a=0, b=0, op_valid=0, busy=0, done=0, pass_cnt=0. In-flight reads and buffered words are discarded.
- Output buffer is a FIFO of depth RD_LAT+1.
  - in_flight counts issued reads whose data has not yet returned.
  - Returning douta is written into the FIFO exactly RD_LAT cycles after its ena cycle, tracked by an RD_LAT-deep valid shift register.
- Issue rule: in RUN, ena=1 iff fifo_count + in_flight − (pop this cycle) < RD_LAT+1. This guarantees no overflow under arbitrary op_ready stalls. Full throughput is one word per cycle when op_ready is held high.
- FIFO head drives a, b and op_valid. a and b hold stable while op_valid && !op_ready. On reset or when the FIFO is empty, a, b = 0.
- States:
  - IDLE: start_stop=1 -> RUN; addr=0, pass_cnt=0.
  - RUN: on each issue, addr increments.
    - Issue at addr=NUM_WORDS-1 ends the pass: pass_cnt increments. If LOOP_MODE=1 and start_stop=1, addr wraps to 0 and the state stays RUN. Otherwise -> DRAIN.
    - start_stop=0 in RUN -> DRAIN with no further issue (a partial pass is not counted).
  - DRAIN: no issue; -> DONE when in_flight=0 and FIFO empty.
  - DONE: done=1 for one cycle; -> IDLE.
- If start_stop rises in DRAIN or DONE, it is ignored until IDLE. A new run always restarts at address 0.
- Simultaneous events:
  - Push and pop in the same cycle is legal at any occupancy, including full.
  - Reaching the last address while start_stop falls in the same cycle: the pass counts and the state goes to DRAIN.
- NUM_WORDS=1: each pass issues only address 0.

Optional Feature:
OPSEQ_CHECKSUM_EN: when defined, adds output port checksum [2*OP_W-1:0].
- It is the modulo 2**(2*OP_W) sum of every delivered word {a,b}, updated on each handshake.
- It clears to 0 on reset and on IDLE->RUN, and holds its value in DONE and IDLE for readback.
- When not defined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package opseq_pkg: state enum (IDLE, RUN, DRAIN, DONE), the PASS_CNT_W=8 constant, and a function to split a word into a and b.
- One sub-module, opseq_fifo: parametrised synchronous FIFO (width 2*OP_W, depth RD_LAT+1) with count output and simultaneous push/pop.

Test Plan:
- Defaults, RAM[i]={i+1,i+2}, start_stop held 1 for 40 cycles, op_ready=1 -> 16 transfers (1,2)..(16,17) on consecutive cycles, done pulses once, pass_cnt=1, ena low after address 15.
- RD_LAT=3, op_ready toggling 1010 -> no word lost or duplicated, ena never raises in_flight+fifo_count above 4, order preserved.
- LOOP_MODE=1, start_stop held for 50 issues, then dropped -> addresses wrap 15->0, pass_cnt=3, remaining in-flight words delivered, then done.
- start_stop dropped after 5 issues, op_ready=0 for 10 cycles then 1 -> 5 words delivered, pass_cnt=0, done after the last pop.
- reset asserted asynchronously mid-RUN with FIFO full -> all outputs 0 immediately; restart begins at address 0.
- OPSEQ_CHECKSUM_EN, default single pass with the RAM above -> checksum = sum of {i+1,i+2} for i=0..15 = 0x0088_0098.

Source files
------------

// File: rtl/opseq_pkg.sv
// opseq_pkg: shared state encoding, pass counter width and operand split helper
// for the operand_sequencer block.
`default_nettype none

package opseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } opseq_state_e;

  localparam int PASS_CNT_W = 8;
  localparam int OPW_MAX    = 64;

  // Returns the upper (hi=1) or lower (hi=0) op_w-bit half of a packed pair,
  // zero-extended to OPW_MAX so callers of any operand width can truncate.
  function automatic logic [OPW_MAX-1:0] split_word(
    input logic [2*OPW_MAX-1:0] word,
    input int unsigned          op_w,
    input logic                 hi
  );
    logic [2*OPW_MAX-1:0] mask;
    mask = {(2*OPW_MAX){1'b1}} >> (2*OPW_MAX - op_w);
    if (hi) return OPW_MAX'((word >> op_w) & mask);
    else    return OPW_MAX'(word & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/opseq_fifo.sv
// opseq_fifo: synchronous FIFO with occupancy count; push and pop may coincide
// at any occupancy, including full.
`default_nettype none

module opseq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/operand_sequencer.sv
// operand_sequencer: walks the operand BRAM, absorbs its read latency and hands
// {a,b} pairs downstream on valid/ready. Optional OPSEQ_CHECKSUM_EN adds a checksum port.
`default_nettype none

module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int OP_W      = 16,
  parameter int ADDR_W    = 4,
  parameter int NUM_WORDS = 16,
  parameter int RD_LAT    = 1,
  parameter int LOOP_MODE = 0
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic [2*OP_W-1:0]     douta,
  output logic [ADDR_W-1:0]     addra,
  output logic                  ena,
  output logic [OP_W-1:0]       a,
  output logic [OP_W-1:0]       b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic                  busy,
  output logic                  done,
`ifdef OPSEQ_CHECKSUM_EN
  output logic [PASS_CNT_W-1:0] pass_cnt,
  output logic [2*OP_W-1:0]     checksum
`else
  output logic [PASS_CNT_W-1:0] pass_cnt
`endif
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = $clog2(2 * DEPTH + 1);

  opseq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [PASS_CNT_W-1:0] pass_q, pass_d;
  logic [RD_LAT-1:0]     rd_vld_q;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_empty;
  logic [2*OP_W-1:0]     fifo_head;
  logic [OCC_W-1:0]      in_flight;
  logic [OCC_W-1:0]      occupancy;
  logic                  pop, issue;

  opseq_fifo #(
    .WIDTH (2 * OP_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clka),
    .rst_i   (reset),
    .push_i  (rd_vld_q[RD_LAT-1]),
    .wdata_i (douta),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + OCC_W'(rd_vld_q[i]);
  end

  // Every issued read already owns a FIFO slot, so stalls can never overflow it.
  assign op_valid  = !fifo_empty;
  assign pop       = op_valid && op_ready;
  assign occupancy = OCC_W'(fifo_cnt) + in_flight - OCC_W'(pop);
  assign issue     = (state_q == RUN) && start_stop && (occupancy < OCC_W'(DEPTH));

  assign ena      = issue;
  assign addra    = addr_q;
  assign pass_cnt = pass_q;
  assign a = op_valid ? OP_W'(split_word((2*OPW_MAX)'(fifo_head), OP_W, 1'b1)) : '0;
  assign b = op_valid ? OP_W'(split_word((2*OPW_MAX)'(fifo_head), OP_W, 1'b0)) : '0;

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      pass_q   <= '0;
      rd_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pass_q   <= pass_d;
      rd_vld_q <= RD_LAT'({rd_vld_q, issue});
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop) begin
          state_d = RUN;
          addr_d  = '0;
          pass_d  = '0;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!start_stop) begin
          state_d = DRAIN;
        end else if (issue) begin
          if (addr_q == ADDR_W'(NUM_WORDS - 1)) begin
            pass_d = pass_q + 1'b1;
            addr_d = '0;
            if (LOOP_MODE == 0) state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (fifo_empty && (in_flight == '0)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef OPSEQ_CHECKSUM_EN
  logic [2*OP_W-1:0] checksum_q;

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if ((state_q == IDLE) && start_stop) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q + fifo_head;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

`default_nettype wire
